// File: rtl/spi_slave_sync.sv
// SPI slave that oversamples SCK/nSS/MOSI on the system clock and moves whole words
// through an RX holding register and a single-entry TX buffer.
module spi_slave_sync #(
   parameter int WIDTH       = 16,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clkIN,
   input  logic             reset_spi,
   input  logic             nSSIN,
   input  logic             SCKIN,
   input  logic             MOSIIN,
   output logic             MISOOUT,
   output logic [WIDTH-1:0] dataOUT,
   output logic             rx_valid,
   input  logic             rx_ack,
   input  logic [WIDTH-1:0] dataIN,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic             busy,
   output logic             overrun,
   output logic             underrun,
   output logic             frame_err
);
   // state     | meaning
   // WAIT_IDLE | after reset; waits for fresh samples and nSS high
   // IDLE      | deselected, waiting for nSS to fall
   // ACTIVE    | selected, shifting words
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

   localparam logic CPOL_L = (CPOL != 0);
   localparam logic CPHA_L = (CPHA != 0);
   localparam logic MSB_L  = (MSB_FIRST != 0);
   localparam int   CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [1:0]    WAIT_INIT = 2'(SYNC_STAGES);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   nss_prev_q, nss_prev_d;
   logic                   sck_prev_q, sck_prev_d;
   logic [1:0]             wait_cnt_q, wait_cnt_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0]       tx_buf_q, tx_buf_d;
   logic                   tx_full_q, tx_full_d;
   logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
   logic                   miso_q, miso_d;
   logic                   und_pend_q, und_pend_d;
   logic                   overrun_q, overrun_d;
   logic                   underrun_q, underrun_d;
   logic                   frame_err_q, frame_err_d;

   logic nss_s, sck_s, mosi_s;
   logic nss_fall, nss_rise, sck_rise, sck_fall;
   logic sample_edge, shift_edge, tx_first;
   logic word_start;
   logic [WIDTH-1:0] rx_next;

   assign nss_s    = nss_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign nss_fall = nss_prev_q & ~nss_s;
   assign nss_rise = ~nss_prev_q & nss_s;
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   assign sample_edge = (CPHA_L ^ CPOL_L) ? sck_fall : sck_rise;
   assign shift_edge  = (CPHA_L ^ CPOL_L) ? sck_rise : sck_fall;
   assign tx_first    = MSB_L ? tx_shift_q[WIDTH-1] : tx_shift_q[0];

   always_comb begin
      state_d     = state_q;
      nss_sync_d  = {nss_sync_q[SYNC_STAGES-2:0], nSSIN};
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCKIN};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSIIN};
      nss_prev_d  = nss_s;
      sck_prev_d  = sck_s;
      wait_cnt_d  = wait_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      data_d      = data_q;
      rx_valid_d  = rx_valid_q & ~rx_ack;
      tx_buf_d    = tx_buf_q;
      tx_full_d   = tx_full_q;
      tx_shift_d  = tx_shift_q;
      miso_d      = miso_q;
      und_pend_d  = und_pend_q;
      overrun_d   = 1'b0;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
      word_start  = 1'b0;
      rx_next     = MSB_L ? {rx_shift_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift_q[WIDTH-1:1]};

      case (state_q)
         WAIT_IDLE: begin
            // Let the synchronizers refill with real pin samples before trusting nSS.
            bit_cnt_d = '0;
            if (wait_cnt_q != 2'd0) wait_cnt_d = wait_cnt_q - 2'd1;
            else if (nss_s) state_d = IDLE;
         end
         IDLE: begin
            if (nss_fall) begin
               state_d    = ACTIVE;
               word_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (nss_rise) begin
               state_d    = IDLE;
               bit_cnt_d  = '0;
               und_pend_d = 1'b0;
               miso_d     = 1'b0;
               if (bit_cnt_q != '0) frame_err_d = 1'b1;
            end else begin
               if (sample_edge) begin
                  rx_shift_d = rx_next;
                  // Underrun is reported only once an empty-loaded word actually clocks.
                  if (und_pend_q && bit_cnt_q == '0) begin
                     underrun_d = 1'b1;
                     und_pend_d = 1'b0;
                  end
                  if (bit_cnt_q == CNT_LAST) begin
                     bit_cnt_d  = '0;
                     data_d     = rx_next;
                     rx_valid_d = 1'b1;
                     overrun_d  = rx_valid_q & ~rx_ack;
                     word_start = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
               // CPHA=0: the trailing edge right after completion belongs to the old word.
               if (shift_edge && (CPHA_L || bit_cnt_q != '0)) begin
                  miso_d     = tx_first;
                  tx_shift_d = MSB_L ? {tx_shift_q[WIDTH-2:0], 1'b0} : {1'b0, tx_shift_q[WIDTH-1:1]};
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase

      if (word_start) begin
         if (tx_full_q) begin
            tx_shift_d = tx_buf_q;
            tx_full_d  = 1'b0;
         end else if (tx_load) begin
            tx_shift_d = dataIN;
         end else begin
            tx_shift_d = '0;
            und_pend_d = 1'b1;
         end
      end else if (tx_load && !tx_full_q) begin
         tx_buf_d  = dataIN;
         tx_full_d = 1'b1;
      end
   end

   always_ff @(posedge clkIN or negedge reset_spi) begin
      if (!reset_spi) begin
         state_q     <= WAIT_IDLE;
         nss_sync_q  <= '1;
         sck_sync_q  <= {SYNC_STAGES{CPOL_L}};
         mosi_sync_q <= '0;
         nss_prev_q  <= 1'b1;
         sck_prev_q  <= CPOL_L;
         wait_cnt_q  <= WAIT_INIT;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         data_q      <= '0;
         rx_valid_q  <= 1'b0;
         tx_buf_q    <= '0;
         tx_full_q   <= 1'b0;
         tx_shift_q  <= '0;
         miso_q      <= 1'b0;
         und_pend_q  <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         nss_sync_q  <= nss_sync_d;
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         nss_prev_q  <= nss_prev_d;
         sck_prev_q  <= sck_prev_d;
         wait_cnt_q  <= wait_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         data_q      <= data_d;
         rx_valid_q  <= rx_valid_d;
         tx_buf_q    <= tx_buf_d;
         tx_full_q   <= tx_full_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         und_pend_q  <= und_pend_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign busy      = (state_q == ACTIVE);
   assign MISOOUT   = busy & (CPHA_L ? miso_q : tx_first);
   assign dataOUT   = data_q;
   assign rx_valid  = rx_valid_q;
   assign tx_ready  = ~tx_full_q;
   assign overrun   = overrun_q;
   assign underrun  = underrun_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-0 16-bit MSB-first instance and a mode-3 8-bit
// LSB-first instance driven by simple bit-banged masters.
`timescale 1ns/1ps
module tb_spi_slave_sync;
   localparam int HALF = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        nss_a, sck_a, mosi_a, miso_a, rx_valid_a, rx_ack_a, tx_load_a;
   logic        tx_ready_a, busy_a, ovr_a, und_a, ferr_a;
   logic [15:0] data_out_a, data_in_a;
   logic        nss_b, sck_b, mosi_b, miso_b, rx_valid_b, rx_ack_b, tx_load_b;
   logic        tx_ready_b, busy_b, ovr_b, und_b, ferr_b;
   logic [7:0]  data_out_b, data_in_b;

   spi_slave_sync #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut_a (
      .clkIN(clk), .reset_spi(rst_n), .nSSIN(nss_a), .SCKIN(sck_a), .MOSIIN(mosi_a),
      .MISOOUT(miso_a), .dataOUT(data_out_a), .rx_valid(rx_valid_a), .rx_ack(rx_ack_a),
      .dataIN(data_in_a), .tx_load(tx_load_a), .tx_ready(tx_ready_a), .busy(busy_a),
      .overrun(ovr_a), .underrun(und_a), .frame_err(ferr_a));

   spi_slave_sync #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(3)) dut_b (
      .clkIN(clk), .reset_spi(rst_n), .nSSIN(nss_b), .SCKIN(sck_b), .MOSIIN(mosi_b),
      .MISOOUT(miso_b), .dataOUT(data_out_b), .rx_valid(rx_valid_b), .rx_ack(rx_ack_b),
      .dataIN(data_in_b), .tx_load(tx_load_b), .tx_ready(tx_ready_b), .busy(busy_b),
      .overrun(ovr_b), .underrun(und_b), .frame_err(ferr_b));

   int tests = 0;
   int fails = 0;

   // Monitors: event counters plus the received-word stream of instance A.
   logic [15:0] got_a[$];
   logic [15:0] exp_a[$];
   int   rd_a = 0;
   logic rxv_prev_a = 1'b0, rxv_prev_b = 1'b0;
   int   rise_a = 0, ovr_cnt_a = 0, und_cnt_a = 0, ferr_cnt_a = 0;
   int   rise_b = 0, ovr_cnt_b = 0, und_cnt_b = 0;

   always @(negedge clk) begin
      rxv_prev_a <= rx_valid_a;
      rxv_prev_b <= rx_valid_b;
      if ((rx_valid_a && !rxv_prev_a) || ovr_a) got_a.push_back(data_out_a);
      if (rx_valid_a && !rxv_prev_a) rise_a <= rise_a + 1;
      if (rx_valid_b && !rxv_prev_b) rise_b <= rise_b + 1;
      ovr_cnt_a  <= ovr_cnt_a + int'(ovr_a);
      und_cnt_a  <= und_cnt_a + int'(und_a);
      ferr_cnt_a <= ferr_cnt_a + int'(ferr_a);
      ovr_cnt_b  <= ovr_cnt_b + int'(ovr_b);
      und_cnt_b  <= und_cnt_b + int'(und_b);
   end

   logic [15:0] miso_word_a;
   logic [7:0]  miso_word_b;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sel_a(input logic v);
      tick(8); nss_a = v; tick(8);
   endtask

   task automatic sel_b(input logic v);
      tick(8); nss_b = v; tick(8);
   endtask

   // Mode 0 master, MSB first: data set while SCK low, MISO read just before the rise.
   task automatic bits_a(input logic [15:0] w, input int n);
      miso_word_a = '0;
      for (int i = 0; i < n; i++) begin
         mosi_a = w[15-i];
         tick(HALF);
         miso_word_a[15-i] = miso_a;
         sck_a = 1'b1;
         tick(HALF);
         sck_a = 1'b0;
      end
   endtask

   // Mode 3 master, LSB first: falling edge drives, rising edge samples.
   task automatic bits_b(input logic [7:0] w, input int from, input int to);
      for (int i = from; i < to; i++) begin
         sck_b  = 1'b0;
         mosi_b = w[i];
         tick(HALF);
         miso_word_b[i] = miso_b;
         sck_b = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic test_reset;
      tick(3);
      tests++; if (data_out_a !== 16'h0000) begin fails++; $display("FAIL reset_data_a: got %h expected 0000", data_out_a); end
      tests++; if (rx_valid_a !== 1'b0) begin fails++; $display("FAIL reset_rx_valid_a: got %b expected 0", rx_valid_a); end
      tests++; if (tx_ready_a !== 1'b1) begin fails++; $display("FAIL reset_tx_ready_a: got %b expected 1", tx_ready_a); end
      tests++; if ({busy_a, miso_a, ovr_a, und_a, ferr_a} !== 5'b0) begin fails++; $display("FAIL reset_flags_a: got %b expected 00000", {busy_a, miso_a, ovr_a, und_a, ferr_a}); end
      tests++; if ({busy_b, miso_b, rx_valid_b, tx_ready_b} !== 4'b0001) begin fails++; $display("FAIL reset_flags_b: got %b expected 0001", {busy_b, miso_b, rx_valid_b, tx_ready_b}); end
      rst_n = 1'b1;
      tick(10);
   endtask

   task automatic test_mode0;
      int r0;
      data_in_a = 16'h1234; tx_load_a = 1'b1; tick(1); tx_load_a = 1'b0;
      tests++; if (tx_ready_a !== 1'b0) begin fails++; $display("FAIL mode0_buf_full: got tx_ready %b expected 0", tx_ready_a); end
      r0 = rise_a;
      exp_a.push_back(16'hA5C3);
      sel_a(1'b0);
      tests++; if (tx_ready_a !== 1'b1) begin fails++; $display("FAIL mode0_tx_ready_after_start: got %b expected 1", tx_ready_a); end
      tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL mode0_busy: got %b expected 1", busy_a); end
      bits_a(16'hA5C3, 16);
      sel_a(1'b1);
      tests++; if (miso_word_a !== 16'h1234) begin fails++; $display("FAIL mode0_miso: got %h expected 1234", miso_word_a); end
      tests++; if (rise_a - r0 !== 1) begin fails++; $display("FAIL mode0_rx_valid_rises: got %0d expected 1", rise_a - r0); end
      tests++; if (rx_valid_a !== 1'b1) begin fails++; $display("FAIL mode0_rx_valid: got %b expected 1", rx_valid_a); end
      while (exp_a.size() > 0) begin
         logic [15:0] e = exp_a.pop_front();
         tests++;
         if (rd_a >= got_a.size()) begin fails++; $display("FAIL mode0_word: none captured, expected %h", e); end
         else begin
            if (got_a[rd_a] !== e) begin fails++; $display("FAIL mode0_word: got %h expected %h", got_a[rd_a], e); end
            rd_a++;
         end
      end
   endtask

   task automatic test_underrun_overrun;
      int u0, o0;
      logic [15:0] m1;
      rx_ack_a = 1'b1; tick(1); rx_ack_a = 1'b0;
      tests++; if (rx_valid_a !== 1'b0) begin fails++; $display("FAIL ack_clears: got rx_valid %b expected 0", rx_valid_a); end
      u0 = und_cnt_a; o0 = ovr_cnt_a;
      exp_a.push_back(16'h3C5A);
      exp_a.push_back(16'h0F0F);
      sel_a(1'b0);
      bits_a(16'h3C5A, 16);
      m1 = miso_word_a;
      bits_a(16'h0F0F, 16);
      sel_a(1'b1);
      tests++; if (und_cnt_a - u0 !== 2) begin fails++; $display("FAIL b2b_underruns: got %0d expected 2", und_cnt_a - u0); end
      tests++; if (ovr_cnt_a - o0 !== 1) begin fails++; $display("FAIL b2b_overruns: got %0d expected 1", ovr_cnt_a - o0); end
      tests++; if (data_out_a !== 16'h0F0F) begin fails++; $display("FAIL b2b_data: got %h expected 0f0f", data_out_a); end
      tests++; if ({m1, miso_word_a} !== 32'h0) begin fails++; $display("FAIL b2b_miso_zero: got %h expected 00000000", {m1, miso_word_a}); end
      while (exp_a.size() > 0) begin
         logic [15:0] e = exp_a.pop_front();
         tests++;
         if (rd_a >= got_a.size()) begin fails++; $display("FAIL b2b_word: none captured, expected %h", e); end
         else begin
            if (got_a[rd_a] !== e) begin fails++; $display("FAIL b2b_word: got %h expected %h", got_a[rd_a], e); end
            rd_a++;
         end
      end
   endtask

   task automatic test_frame_err;
      int f0, r0;
      f0 = ferr_cnt_a;
      sel_a(1'b0);
      bits_a(16'hFFFF, 5);
      sel_a(1'b1);
      tests++; if (ferr_cnt_a - f0 !== 1) begin fails++; $display("FAIL frame_err_pulses: got %0d expected 1", ferr_cnt_a - f0); end
      tests++; if (rx_valid_a !== 1'b1) begin fails++; $display("FAIL frame_err_rx_valid: got %b expected 1", rx_valid_a); end
      tests++; if (data_out_a !== 16'h0F0F) begin fails++; $display("FAIL frame_err_data_kept: got %h expected 0f0f", data_out_a); end
      rx_ack_a = 1'b1; tick(1); rx_ack_a = 1'b0;
      r0 = rise_a;
      exp_a.push_back(16'hFFFF);
      sel_a(1'b0);
      bits_a(16'hFFFF, 16);
      sel_a(1'b1);
      tests++; if (rise_a - r0 !== 1) begin fails++; $display("FAIL after_frame_err_rises: got %0d expected 1", rise_a - r0); end
      tests++; if (ferr_cnt_a - f0 !== 1) begin fails++; $display("FAIL after_frame_err_no_err: got %0d expected 1", ferr_cnt_a - f0); end
      while (exp_a.size() > 0) begin
         logic [15:0] e = exp_a.pop_front();
         tests++;
         if (rd_a >= got_a.size()) begin fails++; $display("FAIL after_frame_err_word: none captured, expected %h", e); end
         else begin
            if (got_a[rd_a] !== e) begin fails++; $display("FAIL after_frame_err_word: got %h expected %h", got_a[rd_a], e); end
            rd_a++;
         end
      end
   endtask

   task automatic test_mode3_lsb;
      int r0;
      logic exp_order[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      data_in_b = 8'h3C; tx_load_b = 1'b1; tick(1); tx_load_b = 1'b0;
      r0 = rise_b;
      miso_word_b = '0;
      sel_b(1'b0);
      bits_b(8'h81, 0, 8);
      sel_b(1'b1);
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (miso_word_b[i] !== exp_order[i]) begin fails++; $display("FAIL mode3_miso_bit%0d: got %b expected %b", i, miso_word_b[i], exp_order[i]); end
      end
      tests++; if (data_out_b !== 8'h81) begin fails++; $display("FAIL mode3_data: got %h expected 81", data_out_b); end
      tests++; if (rise_b - r0 !== 1) begin fails++; $display("FAIL mode3_rises: got %0d expected 1", rise_b - r0); end
   endtask

   task automatic test_back_to_back;
      int o0, u0;
      logic [7:0] m1;
      rx_ack_b = 1'b1; tick(1); rx_ack_b = 1'b0;
      o0 = ovr_cnt_b; u0 = und_cnt_b;
      data_in_b = 8'h3C; tx_load_b = 1'b1; tick(1); tx_load_b = 1'b0;
      miso_word_b = '0;
      sel_b(1'b0);
      bits_b(8'h81, 0, 3);
      tests++; if (tx_ready_b !== 1'b1) begin fails++; $display("FAIL b2b_b_ready_midword: got %b expected 1", tx_ready_b); end
      data_in_b = 8'hA5; tx_load_b = 1'b1; tick(1); tx_load_b = 1'b0;
      bits_b(8'h81, 3, 8);
      m1 = miso_word_b;
      bits_b(8'h7E, 0, 8);
      sel_b(1'b1);
      tests++; if (m1 !== 8'h3C) begin fails++; $display("FAIL b2b_b_miso1: got %h expected 3c", m1); end
      tests++; if (miso_word_b !== 8'hA5) begin fails++; $display("FAIL b2b_b_miso2: got %h expected a5", miso_word_b); end
      tests++; if (data_out_b !== 8'h7E) begin fails++; $display("FAIL b2b_b_data: got %h expected 7e", data_out_b); end
      tests++; if (ovr_cnt_b - o0 !== 1) begin fails++; $display("FAIL b2b_b_overrun: got %0d expected 1", ovr_cnt_b - o0); end
      tests++; if (und_cnt_b - u0 !== 0) begin fails++; $display("FAIL b2b_b_underrun: got %0d expected 0", und_cnt_b - u0); end
   endtask

   task automatic test_reset_midframe;
      int g0, r0;
      data_in_a = 16'hBEEF; tx_load_a = 1'b1; tick(1); tx_load_a = 1'b0;
      sel_a(1'b0);
      bits_a(16'h1357, 7);
      rst_n = 1'b0;
      tick(3);
      tests++; if (data_out_a !== 16'h0000) begin fails++; $display("FAIL midrst_data: got %h expected 0000", data_out_a); end
      tests++; if ({rx_valid_a, busy_a, miso_a, tx_ready_a} !== 4'b0001) begin fails++; $display("FAIL midrst_flags: got %b expected 0001", {rx_valid_a, busy_a, miso_a, tx_ready_a}); end
      rst_n = 1'b1;
      tick(2);
      g0 = got_a.size();
      bits_a(16'hFFFF, 16);
      tick(8);
      tests++; if (got_a.size() !== g0) begin fails++; $display("FAIL midrst_ignored: got %0d words expected %0d", got_a.size(), g0); end
      tests++; if ({busy_a, rx_valid_a} !== 2'b00) begin fails++; $display("FAIL midrst_idle: got %b expected 00", {busy_a, rx_valid_a}); end
      sel_a(1'b1);
      r0 = rise_a;
      exp_a.push_back(16'h00FF);
      sel_a(1'b0);
      bits_a(16'h00FF, 16);
      sel_a(1'b1);
      tests++; if (rise_a - r0 !== 1) begin fails++; $display("FAIL midrst_next_rises: got %0d expected 1", rise_a - r0); end
      tests++; if (miso_word_a !== 16'h0000) begin fails++; $display("FAIL midrst_miso: got %h expected 0000", miso_word_a); end
      while (exp_a.size() > 0) begin
         logic [15:0] e = exp_a.pop_front();
         tests++;
         if (rd_a >= got_a.size()) begin fails++; $display("FAIL midrst_word: none captured, expected %h", e); end
         else begin
            if (got_a[rd_a] !== e) begin fails++; $display("FAIL midrst_word: got %h expected %h", got_a[rd_a], e); end
            rd_a++;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      nss_a = 1'b1; sck_a = 1'b0; mosi_a = 1'b0; rx_ack_a = 1'b0; tx_load_a = 1'b0; data_in_a = '0;
      nss_b = 1'b1; sck_b = 1'b1; mosi_b = 1'b0; rx_ack_b = 1'b0; tx_load_b = 1'b0; data_in_b = '0;
      test_reset();
      test_mode0();
      test_underrun_overrun();
      test_frame_err();
      test_mode3_lsb();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter WIDTH, default 16, word length in bits; legal range 2..32.
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB shifted first on both MOSI and MISO, 0 = LSB first.
REQ-005 Parameter SYNC_STAGES, default 2, synchronizer depth for SCKIN/nSSIN/MOSIIN; legal range 2..3.
REQ-006 clkIN  input  1  system clock; sole clock of the block; all logic rising-edge.
REQ-007 reset_spi  input  1  asynchronous, active-low reset.
REQ-008 nSSIN  input  1  SPI slave select, active low, asynchronous to clkIN.
REQ-009 SCKIN  input  1  SPI serial clock, asynchronous; sampled only, never used as a clock.
REQ-010 MOSIIN  input  1  SPI master-out data.
REQ-011 MISOOUT  output  1  SPI master-in data.
REQ-012 dataOUT  output  WIDTH  last completed received word.
REQ-013 rx_valid  output  1  dataOUT holds an unacknowledged word.
REQ-014 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-015 dataIN  input  WIDTH  next word to transmit.
REQ-016 tx_load  input  1  write dataIN into the TX buffer; honoured only while tx_ready=1.
REQ-017 tx_ready  output  1  TX buffer empty.
REQ-018 busy  output  1  FSM in ACTIVE.
REQ-019 overrun  output  1  one-cycle pulse: word completed while rx_valid=1.
REQ-020 underrun  output  1  one-cycle pulse: word started with TX buffer empty.
REQ-021 frame_err  output  1  one-cycle pulse: nSS deasserted with a partial word.

Function
REQ-022 SCKIN, nSSIN, MOSIIN shall each pass through SYNC_STAGES flops; edges shall be detected by comparing the last two synchronized samples.
REQ-023 Leading edge = rising if CPOL=0, falling if CPOL=1; sample edge = leading if CPHA=0, else trailing; the opposite edge is the shift edge.
REQ-024 Supported SCK frequency: at most clkIN/4; nSS fall to first SCK edge and last SCK edge to nSS rise each at least SYNC_STAGES+2 clkIN cycles.
REQ-025 FSM states: WAIT_IDLE, IDLE, ACTIVE.
- WAIT_IDLE -> IDLE when synchronized nSS=1.
- IDLE -> ACTIVE on synchronized nSS falling edge.
- ACTIVE -> IDLE on synchronized nSS rising edge.
REQ-026 Word start (nSS fall in IDLE, or the cycle a word completes while still ACTIVE):
- TX buffer full: load it into the TX shift register; buffer becomes empty.
- TX buffer empty: load all-zeros and pulse underrun.
REQ-027 When tx_load=1 coincides with a word start and the buffer is empty, dataIN shall load directly into the TX shift register; buffer stays empty; no underrun.
REQ-028 MISOOUT shall present the current first-order TX bit in ACTIVE; 0 otherwise.
- CPHA=0: first bit valid from word start; advance on each shift edge.
- CPHA=1: advance on each shift edge, including the first.
REQ-029 On each sample edge in ACTIVE, the synchronized MOSI bit shall shift into the RX register in MSB_FIRST order and the bit counter shall increment.
REQ-030 Word completion (WIDTH-th sample edge):
- dataOUT <= assembled word; rx_valid <= 1; counter wraps to 0.
- Same clkIN cycle as edge detection, i.e. SYNC_STAGES+1 clkIN edges after the pin edge is first sampled.
REQ-031 Back-to-back words within one nSS-low frame shall be supported without gaps.
REQ-032 Completion while rx_valid=1: dataOUT overwritten and overrun pulsed. Completion coinciding with rx_ack: rx_valid stays 1 and no overrun.
REQ-033 nSS rise with counter != 0: pulse frame_err; discard the partial word; dataOUT and rx_valid unchanged; counter cleared.
REQ-034 The TX buffer shall retain contents across frames until consumed.

Reset
REQ-035 While reset_spi=0:
- dataOUT=0; rx_valid, overrun, underrun, frame_err, busy, MISOOUT = 0; tx_ready=1.
- Counter 0; TX buffer empty.
- Synchronizers at idle levels (nSS=1, SCK=CPOL, MOSI=0).
- FSM in WAIT_IDLE.
REQ-036 Reset asserted mid-frame shall abort the frame; after release, no word shall be accepted until nSS has been observed high.

Verification
REQ-037 WIDTH=16, mode 0, tx_load 0x1234, master sends 0xA5C3 -> master reads 0x1234, dataOUT=0xA5C3, one rx_valid rise, tx_ready=1 after word start.
REQ-038 CPOL=1, CPHA=1, MSB_FIRST=0, WIDTH=8, send 0x81 with dataIN 0x3C -> dataOUT=0x81, MISO bit order 0,0,1,1,1,1,0,0.
REQ-039 Two words in one frame, no rx_ack, empty TX buffer -> two underrun pulses, one overrun pulse, dataOUT=second word, MISO all zeros.
REQ-040 nSS raised after 5 of 16 bits -> frame_err pulse, rx_valid unchanged; next full frame 0xFFFF received correctly.
REQ-041 reset_spi pulsed low after 7 bits with nSS held low -> outputs at reset values; subsequent SCK edges ignored until nSS high, then next frame 0x00FF received correctly.
